serial_to_parallel_buffered: RTL and testbench
==============================================

Name: serial_to_parallel_buffered

Overview:
- Downstream consumer of the serializer stage. Takes an LSB-first serial bit stream (serial_valid/serial_data) and reassembles it into width-bit words.
- Completed words are queued in a small FIFO and presented on a valid/ready parallel output.
- Absorbs sink backpressure. Flags words lost when the queue is full.

Parameters:
- width, 8: bits per word; ≥ 2.
- depth, 2: output queue entries; power of two, ≥ 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- serial_valid  input  1  serial_data carries a valid bit this cycle
- serial_data  input  1  serial bit, LSB of each word first
- clear  input  1  synchronous discard of partially assembled word
- parallel_valid  output  1  head of queue valid
- parallel_data  output  width  head-of-queue word
- parallel_ready  input  1  sink accepts head word this cycle
- busy  output  1  partial word in progress (bit count ≠ 0)
- overflow  output  1  sticky: a completed word was dropped
- level  output  $clog2(depth)+1  number of queued words

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - bit count = 0, shift register = 0, queue empty.
  - parallel_valid = 0, parallel_data = 0, busy = 0, overflow = 0, level = 0.
  - Reset mid-word discards the partial word; reset with a non-empty queue discards all queued words.
- Assembly:
  - Each cycle with serial_valid = 1, the bit is written at index bit count, and bit count increments.
  - Idle cycles (serial_valid = 0) hold state; gaps inside a word are legal.
  - The bit arriving when bit count = width-1 completes the word. The word is the shift register contents plus that bit at MSB; bit count wraps to 0.
- Push:
  - The completed word is written into the queue at the same clock edge the last bit is sampled.
  - parallel_valid rises one cycle after the cycle in which the last bit was presented (1-cycle latency when the queue was empty).
- Pop:
  - Head is consumed on any edge with parallel_valid & parallel_ready.
  - parallel_data is stable while parallel_valid = 1 and parallel_ready = 0.
  - parallel_data is held at the last value, or 0 after reset, when the queue is empty. Bench must not check it while parallel_valid = 0.
- Queue:
  - Circular buffer with read/write pointers of $clog2(depth) bits, wrapping modulo depth.
  - level tracks occupancy: +1 push only, -1 pop only, unchanged on push+pop or neither.
- Full boundary:
  - A word completing while level = depth and no pop this edge is dropped, and overflow is set (sticky until reset).
  - If a pop occurs on the same edge, the push is accepted and nothing is dropped.
- Empty boundary: parallel_ready with an empty queue has no effect; level never goes below 0.
- Back-to-back words:
  - A continuous serial_valid stream with an always-ready sink yields one parallel_valid pulse every width cycles, with no bit lost.
  - The first bit of the next word may arrive on the cycle immediately after the completing bit.
- clear:
  - Sets bit count to 0 and discards partial bits. It does not affect the queue, level or overflow.
  - clear wins over a simultaneous serial_valid, so that bit is discarded, including a word-completing bit.
- busy: combinational from bit count ≠ 0; it is 0 on the cycle after the completing bit.
- All state except the asynchronous reset path is updated only on the rising edge of clk.

Test Plan:
- Reset, then 8 consecutive serial_valid bits 0,1,0,1,1,0,0,1 (LSB first), ready = 1 → parallel_valid for exactly 1 cycle, one cycle after the last bit, with parallel_data = 8'h9A, level returning to 0, and busy = 1 during bits 2–8, 0 after.
- Same word sent with serial_valid dropped for 3 cycles after bit 4 → identical 8'h9A and no early parallel_valid.
- ready held 0, three words 8'h11, 8'h22, 8'h33 streamed back-to-back →
  - level reaches 2 and overflow = 1 after the third word.
  - After ready is raised, 8'h11 then 8'h22 are popped and 8'h33 is never seen.
- Queue full (2 words), ready = 1 asserted on the exact cycle the third word's last bit arrives → no overflow, and the outputs in order are 8'h11, 8'h22, 8'h33.
- clear after 5 bits, then full word 8'hC3 → output 8'hC3 only; clear on the completing bit cycle produces no word.
- rst_n pulsed low asynchronously mid-clock with 1 queued word and 3 partial bits → outputs zero immediately, and the next full word 8'h5A is received correctly.

Source files
------------

// File: rtl/serial_to_parallel_buffered_if.sv
// Parallel valid/ready word bus carrying assembled words from the buffer to its sink.
interface serial_to_parallel_buffered_if #(
    parameter int unsigned width = 8
);
    logic             parallel_valid;
    logic [width-1:0] parallel_data;
    logic             parallel_ready;

    modport master (
        output parallel_valid,
        output parallel_data,
        input  parallel_ready
    );

    modport slave (
        input  parallel_valid,
        input  parallel_data,
        output parallel_ready
    );
endinterface

// File: rtl/serial_to_parallel_buffered.sv
// Reassembles an LSB-first serial stream into words and queues them in a small
// circular FIFO presented on a valid/ready bus; drops and flags words when full.
module serial_to_parallel_buffered #(
    parameter int unsigned width = 8,
    parameter int unsigned depth = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      serial_valid,
    input  logic                      serial_data,
    input  logic                      clear,
    serial_to_parallel_buffered_if.master par,
    output logic                      busy,
    output logic                      overflow,
    output logic [$clog2(depth):0]    level
);
    localparam int unsigned CntW = $clog2(width);
    localparam int unsigned PtrW = $clog2(depth);
    localparam logic [CntW-1:0] LastBit   = CntW'(width - 1);
    localparam logic [PtrW:0]   LevelFull = (PtrW + 1)'(depth);

    logic [CntW-1:0]  cnt_q;
    logic [width-2:0] sr_q;
    logic [width-1:0] mem_q [depth];
    logic [PtrW-1:0]  rd_ptr_q;
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW:0]    level_q;
    logic [width-1:0] hold_q;
    logic             overflow_q;

    logic             bit_take;
    logic             word_done;
    logic             pop;
    logic             push;
    logic [width-1:0] word;

    // clear outranks a simultaneous serial bit, including a completing one.
    assign bit_take  = serial_valid && !clear;
    assign word_done = bit_take && (cnt_q == LastBit);
    assign word      = {serial_data, sr_q};
    assign pop       = (level_q != '0) && par.parallel_ready;
    // A pop on the same edge frees the slot, so a full queue still accepts.
    assign push      = word_done && ((level_q != LevelFull) || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            sr_q       <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            hold_q     <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (clear) begin
                cnt_q <= '0;
            end else if (serial_valid) begin
                if (word_done) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q       <= cnt_q + CntW'(1);
                    sr_q[cnt_q] <= serial_data;
                end
            end

            if (push) begin
                mem_q[wr_ptr_q] <= word;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                hold_q   <= mem_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end

            case ({push, pop})
                2'b10:   level_q <= level_q + (PtrW + 1)'(1);
                2'b01:   level_q <= level_q - (PtrW + 1)'(1);
                default: level_q <= level_q;
            endcase

            if (word_done && !push) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // An empty queue keeps showing the last word popped (zero after reset).
    assign par.parallel_valid = (level_q != '0);
    assign par.parallel_data  = (level_q != '0) ? mem_q[rd_ptr_q] : hold_q;
    assign busy               = (cnt_q != '0);
    assign overflow           = overflow_q;
    assign level              = level_q;
endmodule

// File: tb/tb_serial_to_parallel_buffered.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_serial_to_parallel_buffered;
    localparam int unsigned W = 8;
    localparam int unsigned D = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic serial_valid = 1'b0;
    logic serial_data = 1'b0;
    logic clear = 1'b0;
    logic busy;
    logic overflow;
    logic [$clog2(D):0] level;

    serial_to_parallel_buffered_if #(.width(W)) par ();

    serial_to_parallel_buffered #(.width(W), .depth(D)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .serial_valid (serial_valid),
        .serial_data  (serial_data),
        .clear        (clear),
        .par          (par.master),
        .busy         (busy),
        .overflow     (overflow),
        .level        (level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: bit counter, partial word, word queue, sticky drop flag.
    int           m_cnt;
    logic [W-1:0] m_part;
    logic [W-1:0] m_q[$];
    logic         m_ovf;
    logic [W-1:0] seen[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] seen_at(input int i);
        return (i < seen.size()) ? 32'(seen[i]) : 32'hDEAD_BEEF;
    endfunction

    task automatic model_reset();
        m_cnt  = 0;
        m_part = '0;
        m_q.delete();
        m_ovf  = 1'b0;
    endtask

    task automatic model_step(input logic sv, input logic sd, input logic clr, input logic rdy);
        if (rdy && m_q.size() > 0) void'(m_q.pop_front());
        if (clr) begin
            m_cnt = 0;
        end else if (sv) begin
            m_part[m_cnt] = sd;
            m_cnt++;
            if (m_cnt == W) begin
                m_cnt = 0;
                if (m_q.size() < D) m_q.push_back(m_part);
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        check("valid", 32'(par.parallel_valid), 32'(m_q.size() != 0));
        check("level", 32'(level), 32'(m_q.size()));
        check("busy", 32'(busy), 32'(m_cnt != 0));
        check("overflow", 32'(overflow), 32'(m_ovf));
        if (m_q.size() != 0) check("data", 32'(par.parallel_data), 32'(m_q[0]));
    endtask

    // Apply inputs for one clock, advance the model, then check after the edge.
    task automatic cycle(input logic sv, input logic sd, input logic clr, input logic rdy);
        serial_valid       = sv;
        serial_data        = sd;
        clear              = clr;
        par.parallel_ready = rdy;
        if (par.parallel_valid && rdy) seen.push_back(par.parallel_data);
        model_step(sv, sd, clr, rdy);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic send_bits(input logic [W-1:0] w, input int first, input int last,
                             input logic rdy);
        for (int i = first; i <= last; i++) cycle(1'b1, w[i], 1'b0, rdy);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, rdy);
    endtask

    task automatic do_reset();
        rst_n              = 1'b0;
        serial_valid       = 1'b0;
        serial_data        = 1'b0;
        clear              = 1'b0;
        par.parallel_ready = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        compare_all();
        check("rst_data", 32'(par.parallel_data), 32'h0);
        rst_n = 1'b1;
        seen.delete();
    endtask

    initial begin
        model_reset();
        par.parallel_ready = 1'b0;

        // Basic word with an always-ready sink.
        do_reset();
        send_bits(8'h9A, 0, W - 1, 1'b1);
        check("t1_valid", 32'(par.parallel_valid), 32'h1);
        check("t1_data", 32'(par.parallel_data), 32'h9A);
        idle(1, 1'b1);
        check("t1_valid_drop", 32'(par.parallel_valid), 32'h0);
        check("t1_level", 32'(level), 32'h0);

        // Same word with a 3-cycle gap after bit 4.
        seen.delete();
        send_bits(8'h9A, 0, 3, 1'b1);
        idle(3, 1'b1);
        check("t2_no_early", 32'(par.parallel_valid), 32'h0);
        send_bits(8'h9A, 4, W - 1, 1'b1);
        check("t2_data", 32'(par.parallel_data), 32'h9A);
        idle(2, 1'b1);
        check("t2_seen", seen_at(0), 32'h9A);

        // Backpressure: third word is dropped.
        do_reset();
        send_bits(8'h11, 0, W - 1, 1'b0);
        send_bits(8'h22, 0, W - 1, 1'b0);
        send_bits(8'h33, 0, W - 1, 1'b0);
        check("t3_level", 32'(level), 32'h2);
        check("t3_ovf", 32'(overflow), 32'h1);
        idle(4, 1'b1);
        check("t3_count", 32'(seen.size()), 32'h2);
        check("t3_w0", seen_at(0), 32'h11);
        check("t3_w1", seen_at(1), 32'h22);

        // Full queue, pop coincides with the completing bit.
        do_reset();
        send_bits(8'h11, 0, W - 1, 1'b0);
        send_bits(8'h22, 0, W - 1, 1'b0);
        send_bits(8'h33, 0, W - 2, 1'b0);
        send_bits(8'h33, W - 1, W - 1, 1'b1);
        check("t4_ovf", 32'(overflow), 32'h0);
        idle(4, 1'b1);
        check("t4_count", 32'(seen.size()), 32'h3);
        check("t4_w0", seen_at(0), 32'h11);
        check("t4_w1", seen_at(1), 32'h22);
        check("t4_w2", seen_at(2), 32'h33);

        // clear mid-word, then clear on the completing bit.
        do_reset();
        send_bits(8'hFF, 0, 4, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        check("t5_busy_clr", 32'(busy), 32'h0);
        send_bits(8'hC3, 0, W - 1, 1'b1);
        idle(2, 1'b1);
        send_bits(8'h77, 0, W - 2, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        idle(2, 1'b1);
        check("t5_count", 32'(seen.size()), 32'h1);
        check("t5_w0", seen_at(0), 32'hC3);

        // Asynchronous reset mid-clock with a queued word and 3 partial bits.
        do_reset();
        send_bits(8'hE7, 0, W - 1, 1'b0);
        send_bits(8'hE7, 0, 2, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("t6_valid", 32'(par.parallel_valid), 32'h0);
        check("t6_data", 32'(par.parallel_data), 32'h0);
        check("t6_level", 32'(level), 32'h0);
        check("t6_busy", 32'(busy), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        seen.delete();
        send_bits(8'h5A, 0, W - 1, 1'b1);
        idle(2, 1'b1);
        check("t6_count", 32'(seen.size()), 32'h1);
        check("t6_w0", seen_at(0), 32'h5A);

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            cycle($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 40) == 0,
                  $urandom_range(0, 2) != 0);
            if (n % 700 == 699) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
